// File: rtl/biriscv_multiplier_iter_if.sv
// Issue and writeback handshake bundle for the iterative multiplier.
// Signal suffixes give direction as seen from the multiplier (slave).
interface biriscv_multiplier_iter_if;
    logic        opcode_valid_i;
    logic        opcode_ready_o;
    logic [1:0]  opcode_op_i;
    logic [4:0]  opcode_rd_idx_i;
    logic [31:0] opcode_ra_operand_i;
    logic [31:0] opcode_rb_operand_i;
    logic        flush_i;
    logic        writeback_valid_o;
    logic        writeback_ready_i;
    logic [31:0] writeback_value_o;
    logic [4:0]  writeback_rd_idx_o;
    logic        busy_o;

    modport slave (
        input  opcode_valid_i,
        output opcode_ready_o,
        input  opcode_op_i,
        input  opcode_rd_idx_i,
        input  opcode_ra_operand_i,
        input  opcode_rb_operand_i,
        input  flush_i,
        output writeback_valid_o,
        input  writeback_ready_i,
        output writeback_value_o,
        output writeback_rd_idx_o,
        output busy_o
    );

    modport master (
        output opcode_valid_i,
        input  opcode_ready_o,
        output opcode_op_i,
        output opcode_rd_idx_i,
        output opcode_ra_operand_i,
        output opcode_rb_operand_i,
        output flush_i,
        input  writeback_valid_o,
        output writeback_ready_i,
        input  writeback_value_o,
        input  writeback_rd_idx_o,
        input  busy_o
    );
endinterface

// File: rtl/biriscv_multiplier_iter.sv
// Iterative RV32M multiplier (MUL/MULH/MULHSU/MULHU): one CHUNK_W-wide slice of B
// is multiplied against the 33-bit extended A and accumulated into a 64-bit sum each cycle.
module biriscv_multiplier_iter #(
    parameter int unsigned CHUNK_W = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    biriscv_multiplier_iter_if.slave   bus
);

    localparam int unsigned NCHUNK = 32 / CHUNK_W;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] OpMul    = 2'd0;
    localparam logic [1:0] OpMulh   = 2'd1;
    localparam logic [1:0] OpMulhsu = 2'd2;

    generate
        if ((CHUNK_W == 0) || ((32 % CHUNK_W) != 0)) begin : g_bad_chunk
            $error("CHUNK_W must divide 32");
        end
    endgenerate

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e             state_q, state_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [1:0]         op_q, op_d;
    logic [4:0]         rd_q, rd_d;
    logic [63:0]        acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic               wb_valid_q, wb_valid_d;
    logic [31:0]        wb_value_q, wb_value_d;
    logic [4:0]         wb_rd_q, wb_rd_d;

    logic signed [32:0]         a_ext;
    logic [5:0]                 shamt;
    logic [31:0]                b_shift;
    logic [CHUNK_W-1:0]         b_chunk;
    logic                       top_chunk;
    logic signed [CHUNK_W:0]    b_ext;
    logic signed [CHUNK_W+33:0] prod;
    logic signed [127:0]        prod_sx;
    logic [63:0]                acc_sum;

    // Slice datapath: signed 33 x (CHUNK_W+1) product, sign-extended, then placed by chunk index.
    always_comb begin
        a_ext     = ((op_q == OpMulh) || (op_q == OpMulhsu)) ? {a_q[31], a_q} : {1'b0, a_q};
        shamt     = 6'(32'(cnt_q) * CHUNK_W);
        b_shift   = b_q >> shamt;
        b_chunk   = b_shift[CHUNK_W-1:0];
        top_chunk = (cnt_q == CNT_W'(NCHUNK - 1));
        b_ext     = {top_chunk && (op_q == OpMulh) && b_chunk[CHUNK_W-1], b_chunk};
        prod      = a_ext * b_ext;
        prod_sx   = 128'(prod);
        acc_sum   = acc_q + (prod_sx[63:0] << shamt);
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        rd_d       = rd_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        wb_valid_d = wb_valid_q;
        wb_value_d = wb_value_q;
        wb_rd_d    = wb_rd_q;

        case (state_q)
            StIdle: begin
                if (bus.opcode_valid_i) begin
                    a_d     = bus.opcode_ra_operand_i;
                    b_d     = bus.opcode_rb_operand_i;
                    op_d    = bus.opcode_op_i;
                    rd_d    = bus.opcode_rd_idx_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = StCalc;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            StCalc: begin
                acc_d = acc_sum;
                cnt_d = cnt_q + CNT_W'(1);
                if (top_chunk) begin
                    state_d    = StDone;
                    wb_valid_d = 1'b1;
                    wb_value_d = (op_q == OpMul) ? acc_sum[31:0] : acc_sum[63:32];
                    wb_rd_d    = rd_q;
                end
            end
            StDone: begin
                if (bus.writeback_ready_i) begin
                    state_d    = StIdle;
                    wb_valid_d = 1'b0;
                    ready_d    = 1'b1;
                    busy_d     = 1'b0;
                end
            end
            default: begin
                state_d    = StIdle;
                wb_valid_d = 1'b0;
                ready_d    = 1'b1;
                busy_d     = 1'b0;
            end
        endcase

        // Flush wins over accept and over a same-cycle writeback handshake.
        if (bus.flush_i) begin
            state_d    = StIdle;
            wb_valid_d = 1'b0;
            ready_d    = 1'b1;
            busy_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_value_q <= '0;
            wb_rd_q    <= '0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            wb_valid_q <= wb_valid_d;
            wb_value_q <= wb_value_d;
            wb_rd_q    <= wb_rd_d;
        end
    end

    assign bus.opcode_ready_o     = ready_q;
    assign bus.busy_o             = busy_q;
    assign bus.writeback_valid_o  = wb_valid_q;
    assign bus.writeback_value_o  = wb_value_q;
    assign bus.writeback_rd_idx_o = wb_rd_q;

endmodule

// File: tb/tb_biriscv_multiplier_iter.sv
// Scoreboard bench: three multipliers (CHUNK_W 16/8/32) share one stimulus stream;
// expected results are queued at issue and checked by a negedge monitor.
`timescale 1ns/1ps
module tb_biriscv_multiplier_iter;

    localparam int NDUT = 3;
    localparam int NV   = 14;

    typedef struct packed {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
    } vec_t;

    typedef struct packed {
        logic [31:0] val;
        logic [4:0]  rd;
        logic [31:0] issue;
    } exp_t;

    // Hand-computed results.
    localparam vec_t VECS [NV] = '{
        {2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001},
        {2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
        {2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000},
        {2'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000},
        {2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
        {2'd2, 32'h0000_0002, 32'h8000_0000, 32'h0000_0001},
        {2'd0, 32'h1234_5678, 32'h9ABC_DEF0, 32'h242D_2080},
        {2'd0, 32'h0000_0003, 32'h0000_0005, 32'h0000_000F},
        {2'd3, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001},
        {2'd1, 32'h8000_0000, 32'h7FFF_FFFF, 32'hC000_0000},
        {2'd2, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFE},
        {2'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
        {2'd3, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF},
        {2'd0, 32'h0001_0001, 32'h0001_0001, 32'h0002_0001}
    };

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        opv = 1'b0;
    logic [1:0]  op = '0;
    logic [4:0]  rd = '0;
    logic [31:0] ra = '0;
    logic [31:0] rb = '0;
    logic        flush = 1'b0;
    logic        wbr = 1'b1;
    logic        end_chk = 1'b0;

    logic        rdy   [NDUT];
    logic        busy  [NDUT];
    logic        wbv   [NDUT];
    logic [31:0] wbval [NDUT];
    logic [4:0]  wbrd  [NDUT];

    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          n_timeouts = 0;
    exp_t        exp_q [NDUT][$];

    generate
        for (genvar g = 0; g < NDUT; g++) begin : g_dut
            localparam int unsigned W = (g == 0) ? 16 : ((g == 1) ? 8 : 32);
            biriscv_multiplier_iter_if bus_if ();
            assign bus_if.opcode_valid_i      = opv;
            assign bus_if.opcode_op_i         = op;
            assign bus_if.opcode_rd_idx_i     = rd;
            assign bus_if.opcode_ra_operand_i = ra;
            assign bus_if.opcode_rb_operand_i = rb;
            assign bus_if.flush_i             = flush;
            assign bus_if.writeback_ready_i   = wbr;
            assign rdy[g]   = bus_if.opcode_ready_o;
            assign busy[g]  = bus_if.busy_o;
            assign wbv[g]   = bus_if.writeback_valid_o;
            assign wbval[g] = bus_if.writeback_value_o;
            assign wbrd[g]  = bus_if.writeback_rd_idx_o;
            biriscv_multiplier_iter #(.CHUNK_W(W)) u_dut (
                .clk_i (clk),
                .rst_i (rst),
                .bus   (bus_if)
            );
        end
    endgenerate

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int unsigned nchunk_of(input int i);
        return (i == 0) ? 2 : ((i == 1) ? 4 : 1);
    endfunction

    function automatic logic all_idle();
        for (int i = 0; i < NDUT; i++) if (!rdy[i] || wbv[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic all_valid();
        for (int i = 0; i < NDUT; i++) if (!wbv[i]) return 1'b0;
        return 1'b1;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic        prev_flush = 1'b0;
    logic        prev_v     [NDUT];
    logic        prev_hs    [NDUT];
    logic        prev_stall [NDUT];
    logic [31:0] prev_val   [NDUT];
    logic [4:0]  prev_rd    [NDUT];

    task automatic check(input string name, input int idx, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h, expected %h", name, idx, got, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NDUT; i++) begin
            if (rst) begin
                check("rst_ready", i, 32'(rdy[i]), 32'd1);
                check("rst_busy", i, 32'(busy[i]), 32'd0);
                check("rst_valid", i, 32'(wbv[i]), 32'd0);
                check("rst_value", i, wbval[i], 32'd0);
                check("rst_rd", i, 32'(wbrd[i]), 32'd0);
                exp_q[i].delete();
                prev_v[i] = 1'b0;
                prev_hs[i] = 1'b0;
                prev_stall[i] = 1'b0;
            end else begin
                if (prev_flush) begin
                    check("flush_valid", i, 32'(wbv[i]), 32'd0);
                    check("flush_ready", i, 32'(rdy[i]), 32'd1);
                end else if (prev_hs[i]) begin
                    check("release_ready", i, 32'(rdy[i]), 32'd1);
                    check("release_valid", i, 32'(wbv[i]), 32'd0);
                end
                if (prev_stall[i]) begin
                    check("stall_valid", i, 32'(wbv[i]), 32'd1);
                    check("stall_value", i, wbval[i], prev_val[i]);
                    check("stall_rd", i, 32'(wbrd[i]), 32'(prev_rd[i]));
                end
                if (wbv[i]) check("done_ready", i, 32'(rdy[i]), 32'd0);
                if (flush) begin
                    exp_q[i].delete();
                end else begin
                    if (wbv[i] && !prev_v[i] && exp_q[i].size() != 0)
                        check("latency", i, cyc - exp_q[i][0].issue, nchunk_of(i));
                    if (wbv[i] && wbr) begin
                        check("pending", i, 32'(exp_q[i].size() != 0), 32'd1);
                        if (exp_q[i].size() != 0) begin
                            exp_t e;
                            e = exp_q[i].pop_front();
                            check("wb_value", i, wbval[i], e.val);
                            check("wb_rd", i, 32'(wbrd[i]), 32'(e.rd));
                        end
                    end
                end
                prev_v[i]     = wbv[i];
                prev_hs[i]    = wbv[i] && wbr && !flush;
                prev_stall[i] = wbv[i] && !wbr && !flush;
                prev_val[i]   = wbval[i];
                prev_rd[i]    = wbrd[i];
            end
            if (end_chk) check("queue_empty", i, 32'(exp_q[i].size()), 32'd0);
        end
        if (end_chk) check("timeouts", 0, 32'(n_timeouts), 32'd0);
        prev_flush = flush && !rst;
    end

    // ---------------- stimulus ----------------
    // All tasks start and end at posedge + 1ns.
    task automatic issue(input int v, input logic [4:0] dst);
        opv = 1'b1;
        op  = VECS[v].op;
        ra  = VECS[v].a;
        rb  = VECS[v].b;
        rd  = dst;
        for (int i = 0; i < NDUT; i++) exp_q[i].push_back({VECS[v].res, dst, cyc + 1});
        @(posedge clk);
        #1;
        opv = 1'b0;
        ra  = $urandom;
        rb  = $urandom;
        op  = 2'($urandom);
        rd  = 5'($urandom);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 64; k++) begin
            if (all_idle()) return;
            @(posedge clk);
            #1;
        end
        n_timeouts++;
    endtask

    task automatic wait_valid();
        for (int k = 0; k < 64; k++) begin
            if (all_valid()) return;
            @(posedge clk);
            #1;
        end
        n_timeouts++;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < NV; v++) begin
            issue(v, (v == 7) ? 5'd0 : 5'(v + 1));
            wait_idle();
        end

        // Writeback backpressure held for three cycles once all results are up.
        wbr = 1'b0;
        issue(6, 5'd17);
        wait_valid();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        wbr = 1'b1;
        wait_idle();

        // Flush in the second CALC cycle, then a new op right after.
        issue(0, 5'd9);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        issue(10, 5'd10);
        wait_idle();

        // Valid together with flush must not be accepted.
        opv = 1'b1;
        flush = 1'b1;
        ra = 32'h1234_5678;
        rb = 32'h9ABC_DEF0;
        @(posedge clk);
        #1;
        opv = 1'b0;
        flush = 1'b0;
        @(posedge clk);
        #1;
        issue(13, 5'd13);
        wait_idle();

        // Asynchronous reset in CALC, then a full op.
        issue(4, 5'd4);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        issue(9, 5'd30);
        wait_idle();
        issue(11, 5'd31);
        wait_idle();

        end_chk = 1'b1;
        @(posedge clk);
        #1;
        end_chk = 1'b0;
        @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
